// File: rtl/pwm_bank.sv
// Multi-channel PWM bank with a shared prescaler and period counter.
// Duty and period are double-buffered and only reload at a period wrap.
module pwm_bank #(
    parameter int NUM_CH  = 16,
    parameter int CNT_W   = 8,
    parameter int PRESC_W = 8
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [NUM_CH-1:0]       en_out,
    input  logic [NUM_CH-1:0]       en_pwm,
    input  logic [NUM_CH-1:0]       polarity,
    input  logic [NUM_CH*CNT_W-1:0] duty,
    input  logic [CNT_W-1:0]        period,
    input  logic [PRESC_W-1:0]      prescale,
    input  logic                    update_req,
    output logic                    update_ack,
    output logic                    wrap,
    output logic [CNT_W-1:0]        cnt,
    output logic [NUM_CH-1:0]       out
);

    logic [PRESC_W-1:0]             psc;
    logic [NUM_CH-1:0][CNT_W-1:0]   duty_act;
    logic [CNT_W-1:0]               period_act;
    logic                           pending;
    logic                           tick;
    logic                           wrap_tick;
    logic                           load;
    logic [NUM_CH-1:0]              hi;
    logic [NUM_CH-1:0]              out_nxt;

    // >= so that lowering prescale below the running psc ticks at once
    assign tick      = psc >= prescale;
    assign wrap_tick = tick && (cnt >= period_act);
    assign load      = wrap_tick && (pending || update_req);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            psc        <= '0;
            cnt        <= '0;
            duty_act   <= '0;
            period_act <= '1;
            pending    <= 1'b0;
            wrap       <= 1'b0;
            update_ack <= 1'b0;
            out        <= '0;
        end else begin
            psc <= tick ? '0 : psc + PRESC_W'(1);
            if (tick) begin
                cnt <= wrap_tick ? '0 : cnt + CNT_W'(1);
            end
            if (load) begin
                duty_act   <= duty;
                period_act <= period;
            end
            pending    <= load ? 1'b0 : (pending || update_req);
            wrap       <= wrap_tick;
            update_ack <= load;
            out        <= out_nxt;
        end
    end

    always_comb begin
        hi      = '0;
        out_nxt = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            hi[i] = (duty_act[i] > period_act) || (cnt < duty_act[i]);
            out_nxt[i] = en_out[i] &
                         ((en_pwm[i] ? hi[i] : 1'b1) ^ polarity[i]);
        end
    end

endmodule

// File: tb/tb_pwm_bank.sv
// Directed bench for pwm_bank: reset, duty/period buffering,
// wrap-aligned update handshake, prescaler and output stage controls.
module tb_pwm_bank;

    localparam int NUM_CH  = 16;
    localparam int CNT_W   = 8;
    localparam int PRESC_W = 8;

    logic                    clk = 1'b0;
    logic                    rst_n;
    logic [NUM_CH-1:0]       en_out;
    logic [NUM_CH-1:0]       en_pwm;
    logic [NUM_CH-1:0]       polarity;
    logic [NUM_CH*CNT_W-1:0] duty;
    logic [CNT_W-1:0]        period;
    logic [PRESC_W-1:0]      prescale;
    logic                    update_req;
    logic                    update_ack;
    logic                    wrap;
    logic [CNT_W-1:0]        cnt;
    logic [NUM_CH-1:0]       out;

    int total = 0;
    int bad   = 0;
    int hc[NUM_CH];
    int nwrap;
    int nack;
    int first_wrap;
    int ack_hi0;

    pwm_bank #(
        .NUM_CH (NUM_CH),
        .CNT_W  (CNT_W),
        .PRESC_W(PRESC_W)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .en_out    (en_out),
        .en_pwm    (en_pwm),
        .polarity  (polarity),
        .duty      (duty),
        .period    (period),
        .prescale  (prescale),
        .update_req(update_req),
        .update_ack(update_ack),
        .wrap      (wrap),
        .cnt       (cnt),
        .out       (out)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: got %0d want %0d", tag, obs, exp);
        end
    endtask

    task automatic run(input int n);
        for (int i = 0; i < NUM_CH; i++) hc[i] = 0;
        nwrap = 0;
        nack = 0;
        first_wrap = 0;
        for (int k = 1; k <= n; k++) begin
            step();
            for (int i = 0; i < NUM_CH; i++) hc[i] += int'(out[i]);
            if (wrap) begin
                nwrap++;
                if (first_wrap == 0) first_wrap = k;
            end
            nack += int'(update_ack);
        end
    endtask

    // caller raises update_req; it is dropped after the first edge
    task automatic wait_ack(input string tag);
        int n;
        n = 0;
        ack_hi0 = 0;
        do begin
            step();
            update_req = 1'b0;
            ack_hi0 += int'(out[0]);
            n++;
        end while (update_ack !== 1'b1 && n < 2000);
        chk({tag, "_ack"}, 32'(update_ack), 1);
        chk({tag, "_wrap"}, 32'(wrap), 1);
    endtask

    initial begin
        int n;
        rst_n      = 1'b0;
        en_out     = '0;
        en_pwm     = '0;
        polarity   = '0;
        duty       = '0;
        period     = 8'd255;
        prescale   = '0;
        update_req = 1'b0;
        step();
        step();
        chk("rst_cnt", 32'(cnt), 0);
        chk("rst_out", 32'(out), 0);
        chk("rst_wrap", 32'(wrap), 0);
        chk("rst_ack", 32'(update_ack), 0);

        // pending request discarded by a mid-run reset
        rst_n       = 1'b1;
        en_out      = '1;
        en_pwm      = '1;
        duty[0 +: 8] = 8'd64;
        run(280);
        chk("pre_hi0", 32'(hc[0]), 0);
        update_req = 1'b1;
        step();
        update_req = 1'b0;
        run(18);
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
        chk("mid_rst_cnt", 32'(cnt), 0);
        chk("mid_rst_out", 32'(out), 0);
        chk("mid_rst_wrap", 32'(wrap), 0);
        chk("mid_rst_ack", 32'(update_ack), 0);
        run(300);
        chk("discard_ack", 32'(nack), 0);
        chk("discard_hi0", 32'(hc[0]), 0);
        chk("discard_wraps", 32'(nwrap), 1);

        // 25% duty on a 256-count period
        update_req = 1'b1;
        wait_ack("t2");
        chk("t2_cnt0", 32'(cnt), 0);
        run(256);
        chk("t2_hi0", 32'(hc[0]), 64);
        chk("t2_hi1", 32'(hc[1]), 0);
        chk("t2_wraps", 32'(nwrap), 1);
        chk("t2_wrap_pos", 32'(first_wrap), 256);

        // duty edge cases on TOP=99
        duty[8 +: 8]  = 8'd0;
        duty[16 +: 8] = 8'd100;
        duty[24 +: 8] = 8'd50;
        period        = 8'd99;
        update_req    = 1'b1;
        wait_ack("t3");
        run(100);
        chk("t3_hi0", 32'(hc[0]), 64);
        chk("t3_hi1", 32'(hc[1]), 0);
        chk("t3_hi2", 32'(hc[2]), 100);
        chk("t3_hi3", 32'(hc[3]), 50);
        chk("t3_wraps", 32'(nwrap), 1);

        // mid-period duty change waits for the wrap
        n = 0;
        while (cnt !== 8'd10 && n < 200) begin
            step();
            n++;
        end
        chk("t4_cnt10", 32'(cnt), 10);
        duty[0 +: 8] = 8'd128;
        period       = 8'd255;
        update_req   = 1'b1;
        wait_ack("t4");
        chk("t4_old_hi0", 32'(ack_hi0), 54);
        run(255);
        chk("t4_new_hi0", 32'(hc[0]), 128);
        chk("t4_cnt255", 32'(cnt), 255);
        duty[0 +: 8] = 8'd32;
        update_req   = 1'b1;
        step();
        update_req = 1'b0;
        chk("t4_same_ack", 32'(update_ack), 1);
        chk("t4_same_wrap", 32'(wrap), 1);
        run(256);
        chk("t4_same_hi0", 32'(hc[0]), 32);

        // prescaler: 4 clks per count, 10 counts per period
        period     = 8'd9;
        prescale   = 8'd3;
        update_req = 1'b1;
        wait_ack("t5");
        nwrap = 0;
        first_wrap = 0;
        for (int k = 1; k <= 80; k++) begin
            step();
            if (wrap) begin
                nwrap++;
                if (first_wrap == 0) first_wrap = k;
            end
            if (k == 3) chk("t5_cnt_k3", 32'(cnt), 0);
            if (k == 4) chk("t5_cnt_k4", 32'(cnt), 1);
            if (k == 7) chk("t5_cnt_k7", 32'(cnt), 1);
            if (k == 8) chk("t5_cnt_k8", 32'(cnt), 2);
        end
        chk("t5_wraps", 32'(nwrap), 2);
        chk("t5_wrap_pos", 32'(first_wrap), 40);

        // output stage controls on ch4
        prescale      = '0;
        period        = 8'd99;
        duty[32 +: 8] = 8'd25;
        update_req    = 1'b1;
        wait_ack("t6");
        en_out[4] = 1'b0;
        run(2);
        run(100);
        chk("t6_off", 32'(hc[4]), 0);
        chk("t6_ch0", 32'(hc[0]), 32);
        chk("t6_ch2", 32'(hc[2]), 100);
        en_out[4] = 1'b1;
        en_pwm[4] = 1'b0;
        run(2);
        run(100);
        chk("t6_static", 32'(hc[4]), 100);
        en_pwm[4]   = 1'b1;
        polarity[4] = 1'b1;
        run(2);
        run(100);
        chk("t6_inv", 32'(hc[4]), 75);
        en_out[4] = 1'b0;
        run(2);
        run(100);
        chk("t6_off_inv", 32'(hc[4]), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
